dma_channel_arbiter: RTL and testbench
======================================

DMA_CHANNEL_ARBITER -- requirements
Module: dma_channel_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 8, SHALL set the maximum number of GRANT cycles per bus tenure (legal range 1..255).
REQ-002 CLK  input  1  system clock, all state SHALL update on its rising edge.
REQ-003 RST  input  1  reset, asynchronous and active-high.
REQ-004 DREQ  input  4  per-channel transfer requests, bit n = channel n.
REQ-005 MASK  input  4  per-channel disable, 1 = channel ignored.
REQ-006 PRI_ROT  input  1  0 = fixed priority (ch0 highest), 1 = rotating priority.
REQ-007 HLDA  input  1  CPU hold acknowledge.
REQ-008 EOP  input  1  end-of-process pulse from DMAC core for the active channel.
REQ-009 STAT_CLR  input  1  clears TC_STATUS.
REQ-010 HLD  output  1  bus hold request to CPU.
REQ-011 DACK  output  4  one-hot channel acknowledge.
REQ-012 CH_SEL  output  2  index of the granted channel, to DMAC core.
REQ-013 CH_REQ  output  1  DREQ forwarded to DMAC core.
REQ-014 BUSY  output  1  high in any state other than IDLE.
REQ-015 TC_STATUS  output  4  sticky terminal-count flags per channel.

Function
REQ-016 The FSM SHALL have the states IDLE, REQ_BUS, GRANT and RELEASE, and all outputs SHALL be registered.
REQ-017 Eligible set = DREQ & ~MASK, sampled each cycle.
REQ-018 IDLE: if the eligible set is nonzero, the block SHALL latch the winner into CH_SEL, move to REQ_BUS and assert HLD on the next edge; otherwise it SHALL stay in IDLE.
REQ-019 Fixed priority: the winner SHALL be the lowest-index eligible channel.
REQ-020 Rotating priority: the search SHALL start at (last_granted+1) mod 4 and wrap past 3 to 0; last_granted resets to 3, so ch0 is searched first after reset.
REQ-021 REQ_BUS: the block SHALL hold HLD=1 until HLDA=1, then enter GRANT with DACK[CH_SEL]=1, CH_REQ=1 and burst counter=1.
REQ-022 REQ_BUS: if the winner's DREQ drops or becomes masked before HLDA, the block SHALL go to RELEASE without asserting DACK.
REQ-023 GRANT: the 8-bit burst counter SHALL increment once per cycle, and CH_REQ SHALL equal the registered DREQ[CH_SEL].
REQ-024 GRANT exit to RELEASE SHALL occur on the first of: EOP=1, DREQ[CH_SEL]=0, MASK[CH_SEL]=1, or counter==MAX_BURST.
REQ-025 On GRANT exit: DACK=0, CH_REQ=0 and HLD=0 on the same edge, and last_granted SHALL be set to CH_SEL.
REQ-026 GRANT with HLDA falling (CPU preemption): the block SHALL deassert DACK, CH_REQ and HLD on the next edge, go directly to IDLE, and update last_granted.
REQ-027 RELEASE: the block SHALL stay until HLDA=0, then enter IDLE; no new arbitration SHALL occur in RELEASE.
REQ-028 EOP seen in GRANT SHALL set TC_STATUS[CH_SEL]; EOP in any other state SHALL be ignored.
REQ-029 STAT_CLR SHALL clear all TC_STATUS bits; if STAT_CLR and a set occur in the same cycle, the set SHALL win for that bit.
REQ-030 DACK SHALL be one-hot or zero at all times, and nonzero only in GRANT.
REQ-031 A new request arriving during GRANT SHALL NOT preempt the active channel.

Reset
REQ-032 RST=1 SHALL immediately force state=IDLE, HLD=0, DACK=0, CH_SEL=0, CH_REQ=0, BUSY=0, TC_STATUS=0, last_granted=3 and counter=0, independent of CLK.
REQ-033 RST asserted mid-GRANT SHALL drop DACK and HLD without waiting for HLDA.

Verification
REQ-034 Fixed priority, DREQ=4'b0110, MASK=0, HLDA returned 2 cycles after HLD -> CH_SEL=1, DACK=4'b0010 the cycle after HLDA rises.
REQ-035 Rotating priority, DREQ=4'b1111 held, HLDA tracks HLD with 1-cycle delay, MAX_BURST=2 -> grant order 0,1,2,3,0 with each DACK pulse exactly 2 cycles wide.
REQ-036 Channel 2 granted, EOP pulsed in the 3rd GRANT cycle -> TC_STATUS=4'b0100, HLD falls on that edge, STAT_CLR then returns TC_STATUS to 0.
REQ-037 HLDA dropped in the 2nd GRANT cycle -> DACK=0, HLD=0 and state=IDLE on the next edge, and re-arbitration starts the cycle after.
REQ-038 RST pulsed asynchronously (not aligned to a CLK edge) mid-GRANT -> all outputs reach their reset values before the next CLK edge.
REQ-039 DREQ=4'b0001 with MASK=4'b0001 -> HLD stays 0 and BUSY stays 0 for 20 cycles.

Source files
------------

// File: rtl/dma_channel_arbiter.sv
// DMA channel arbiter: picks one of four requesting channels (fixed or
// rotating priority), negotiates the bus with the CPU via HLD/HLDA and
// grants the channel for a bounded burst. Every output is a flop.
module dma_channel_arbiter #(
    parameter int MAX_BURST = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] DREQ,
    input  logic [3:0] MASK,
    input  logic       PRI_ROT,
    input  logic       HLDA,
    input  logic       EOP,
    input  logic       STAT_CLR,
    output logic       HLD,
    output logic [3:0] DACK,
    output logic [1:0] CH_SEL,
    output logic       CH_REQ,
    output logic       BUSY,
    output logic [3:0] TC_STATUS
);

    localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, REQ_BUS, GRANT, RELEASE} state_t;

    state_t     state, state_nxt;
    logic [1:0] last_granted, last_nxt;
    logic [7:0] burst_cnt, cnt_nxt;
    logic [1:0] sel_nxt, winner, start, idx;
    logic       found;
    logic       hld_nxt, ch_req_nxt, busy_nxt;
    logic [3:0] dack_nxt, tc_nxt, tc_set;
    logic [3:0] eligible;

    assign eligible = DREQ & ~MASK;

    // Priority search: start at ch0 (fixed) or one past the last grant (rotating).
    always_comb begin
        winner = 2'd0;
        found  = 1'b0;
        idx    = 2'd0;
        start  = PRI_ROT ? last_granted + 2'd1 : 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (!found && eligible[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Next-state and next-output logic; outputs are computed here and
    // registered below so nothing combinational reaches a port.
    always_comb begin
        state_nxt  = state;
        sel_nxt    = CH_SEL;
        last_nxt   = last_granted;
        cnt_nxt    = burst_cnt;
        hld_nxt    = HLD;
        dack_nxt   = DACK;
        ch_req_nxt = CH_REQ;
        tc_set     = 4'd0;
        case (state)
            IDLE: begin
                hld_nxt    = 1'b0;
                dack_nxt   = 4'd0;
                ch_req_nxt = 1'b0;
                cnt_nxt    = 8'd0;
                if (|eligible) begin
                    sel_nxt   = winner;
                    state_nxt = REQ_BUS;
                    hld_nxt   = 1'b1;
                end
            end
            REQ_BUS: begin
                // A withdrawn request beats a simultaneous HLDA: never ack a dead request.
                if (!eligible[CH_SEL]) begin
                    state_nxt = RELEASE;
                    hld_nxt   = 1'b0;
                end else if (HLDA) begin
                    state_nxt  = GRANT;
                    dack_nxt   = 4'b0001 << CH_SEL;
                    ch_req_nxt = 1'b1;
                    cnt_nxt    = 8'd1;
                end
            end
            GRANT: begin
                if (EOP) tc_set[CH_SEL] = 1'b1;
                if (!HLDA) begin
                    // CPU took the bus back: skip RELEASE, HLDA is already low.
                    state_nxt  = IDLE;
                    hld_nxt    = 1'b0;
                    dack_nxt   = 4'd0;
                    ch_req_nxt = 1'b0;
                    cnt_nxt    = 8'd0;
                    last_nxt   = CH_SEL;
                end else if (EOP || !DREQ[CH_SEL] || MASK[CH_SEL] || burst_cnt == BURST_LIM) begin
                    state_nxt  = RELEASE;
                    hld_nxt    = 1'b0;
                    dack_nxt   = 4'd0;
                    ch_req_nxt = 1'b0;
                    cnt_nxt    = 8'd0;
                    last_nxt   = CH_SEL;
                end else begin
                    cnt_nxt    = burst_cnt + 8'd1;
                    ch_req_nxt = DREQ[CH_SEL];
                end
            end
            RELEASE: begin
                if (!HLDA) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
        // A terminal count in the same cycle as a clear survives the clear.
        tc_nxt   = (STAT_CLR ? 4'd0 : TC_STATUS) | tc_set;
    end

    // State and output registers, asynchronously forced to idle on reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            last_granted <= 2'd3;
            burst_cnt    <= 8'd0;
            HLD          <= 1'b0;
            DACK         <= 4'd0;
            CH_SEL       <= 2'd0;
            CH_REQ       <= 1'b0;
            BUSY         <= 1'b0;
            TC_STATUS    <= 4'd0;
        end else begin
            state        <= state_nxt;
            last_granted <= last_nxt;
            burst_cnt    <= cnt_nxt;
            HLD          <= hld_nxt;
            DACK         <= dack_nxt;
            CH_SEL       <= sel_nxt;
            CH_REQ       <= ch_req_nxt;
            BUSY         <= busy_nxt;
            TC_STATUS    <= tc_nxt;
        end
    end

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Bench for dma_channel_arbiter: two instances (burst 8 and burst 2) share
// one stimulus; directed scenarios plus a randomized run against a
// tenure-level reference model.
module tb_dma_channel_arbiter;

    logic       clk, rst;
    logic [3:0] dreq, mask;
    logic       pri_rot, hlda, eop, stat_clr;

    logic       a_hld, a_ch_req, a_busy;
    logic [3:0] a_dack, a_tc;
    logic [1:0] a_ch_sel;
    logic       b_hld, b_ch_req, b_busy;
    logic [3:0] b_dack, b_tc;
    logic [1:0] b_ch_sel;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phase 0 = no tenure, 1 = waiting for bus,
    // 2 = channel owns bus, 3 = waiting for CPU to drop HLDA.
    int         m_phase[2], m_sel[2], m_last[2], m_cnt[2];
    int         m_burst[2] = '{8, 2};
    logic [3:0] m_tc[2];

    dma_channel_arbiter dut_a (
        .CLK(clk), .RST(rst), .DREQ(dreq), .MASK(mask), .PRI_ROT(pri_rot),
        .HLDA(hlda), .EOP(eop), .STAT_CLR(stat_clr),
        .HLD(a_hld), .DACK(a_dack), .CH_SEL(a_ch_sel), .CH_REQ(a_ch_req),
        .BUSY(a_busy), .TC_STATUS(a_tc)
    );

    dma_channel_arbiter #(.MAX_BURST(2)) dut_b (
        .CLK(clk), .RST(rst), .DREQ(dreq), .MASK(mask), .PRI_ROT(pri_rot),
        .HLDA(hlda), .EOP(eop), .STAT_CLR(stat_clr),
        .HLD(b_hld), .DACK(b_dack), .CH_SEL(b_ch_sel), .CH_REQ(b_ch_req),
        .BUSY(b_busy), .TC_STATUS(b_tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        for (int u = 0; u < 2; u++) begin
            m_phase[u] = 0; m_sel[u] = 0; m_last[u] = 3; m_cnt[u] = 0; m_tc[u] = 4'd0;
        end
    endtask

    task automatic apply_reset;
        rst = 1'b1; dreq = 4'd0; mask = 4'd0; pri_rot = 1'b0;
        hlda = 1'b0; eop = 1'b0; stat_clr = 1'b0;
        tick; tick;
        rst = 1'b0;
        model_reset;
    endtask

    function automatic int pick(logic [3:0] e, int start);
        for (int k = 0; k < 4; k++)
            if (e[(start + k) % 4]) return (start + k) % 4;
        return 0;
    endfunction

    // Advance the model by one clock using the inputs held across that edge.
    task automatic model_step;
        logic [3:0] elig, setb;
        elig = dreq & ~mask;
        for (int u = 0; u < 2; u++) begin
            setb = 4'd0;
            case (m_phase[u])
                0: if (elig != 4'd0) begin
                       m_sel[u]   = pick(elig, pri_rot ? (m_last[u] + 1) % 4 : 0);
                       m_phase[u] = 1;
                   end
                1: if (!elig[m_sel[u]]) m_phase[u] = 3;
                   else if (hlda) begin m_phase[u] = 2; m_cnt[u] = 1; end
                2: begin
                       if (eop) setb[m_sel[u]] = 1'b1;
                       if (!hlda) begin
                           m_phase[u] = 0; m_last[u] = m_sel[u];
                       end else if (eop || !elig[m_sel[u]] || m_cnt[u] == m_burst[u]) begin
                           m_phase[u] = 3; m_last[u] = m_sel[u];
                       end else m_cnt[u]++;
                   end
                default: if (!hlda) m_phase[u] = 0;
            endcase
            if (stat_clr) m_tc[u] = 4'd0;
            m_tc[u] = m_tc[u] | setb;
        end
    endtask

    // Expected {HLD, DACK, CH_SEL, CH_REQ, BUSY, TC_STATUS}.
    function automatic logic [12:0] exp_out(int u);
        logic       own;
        logic [3:0] d;
        own = (m_phase[u] == 2);
        d   = own ? 4'(1 << m_sel[u]) : 4'd0;
        return {(m_phase[u] == 1 || own), d, 2'(m_sel[u]), own, (m_phase[u] != 0), m_tc[u]};
    endfunction

    task automatic test_reset;
        rst = 1'b1; dreq = 4'hf; mask = 4'd0; pri_rot = 1'b0;
        hlda = 1'b1; eop = 1'b0; stat_clr = 1'b0;
        tick;
        n_cmp++;
        if ({a_hld, a_dack, a_ch_sel, a_ch_req, a_busy, a_tc} !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_a: got %b want 0", {a_hld, a_dack, a_ch_sel, a_ch_req, a_busy, a_tc});
        end
        n_cmp++;
        if ({b_hld, b_dack, b_ch_sel, b_ch_req, b_busy, b_tc} !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_b: got %b want 0", {b_hld, b_dack, b_ch_sel, b_ch_req, b_busy, b_tc});
        end
        apply_reset;
    endtask

    task automatic test_fixed_priority;
        apply_reset;
        dreq = 4'b0110;
        tick;
        n_cmp++;
        if ({a_hld, a_ch_sel, a_dack} !== {1'b1, 2'd1, 4'd0}) begin
            n_bad++;
            $display("FAIL fixed_reqbus: hld/sel/dack got %b/%0d/%b want 1/1/0000", a_hld, a_ch_sel, a_dack);
        end
        tick;
        n_cmp++;
        if (a_dack !== 4'd0) begin
            n_bad++;
            $display("FAIL fixed_no_hlda: dack got %b want 0000", a_dack);
        end
        hlda = 1'b1;
        tick;
        n_cmp++;
        if ({a_dack, a_ch_sel, a_ch_req, a_busy} !== {4'b0010, 2'd1, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL fixed_grant: dack/sel/chreq/busy got %b/%0d/%b/%b want 0010/1/1/1",
                     a_dack, a_ch_sel, a_ch_req, a_busy);
        end
    endtask

    task automatic test_rotation;
        int npulse, width, ch, prev;
        int chs[5], wids[5];
        apply_reset;
        pri_rot = 1'b1; dreq = 4'hf;
        npulse = 0; width = 0; ch = 0; prev = 0;
        for (int c = 0; c < 150 && npulse < 5; c++) begin
            tick;
            if (b_dack != 4'd0) begin
                if (width == 0)
                    for (int j = 0; j < 4; j++) if (b_dack[j]) ch = j;
                width++;
            end else if (width > 0) begin
                chs[npulse] = ch; wids[npulse] = width;
                npulse++; width = 0;
            end
            hlda = prev[0];
            prev = int'(b_hld);
        end
        n_cmp++;
        if (npulse < 5) begin
            n_bad++;
            $display("FAIL rotation_timeout: pulses got %0d want 5", npulse);
        end
        for (int i = 0; i < npulse; i++) begin
            n_cmp++;
            if (chs[i] != i % 4 || wids[i] != 2) begin
                n_bad++;
                $display("FAIL rotation_pulse%0d: ch/width got %0d/%0d want %0d/2", i, chs[i], wids[i], i % 4);
            end
        end
    endtask

    task automatic test_eop_tc;
        apply_reset;
        dreq = 4'b0100;
        tick;
        hlda = 1'b1;
        tick; tick; tick;
        n_cmp++;
        if ({a_dack, a_tc} !== {4'b0100, 4'd0}) begin
            n_bad++;
            $display("FAIL eop_pre: dack/tc got %b/%b want 0100/0000", a_dack, a_tc);
        end
        eop = 1'b1;
        tick;
        eop = 1'b0;
        n_cmp++;
        if ({a_tc, a_hld, a_dack} !== {4'b0100, 1'b0, 4'd0}) begin
            n_bad++;
            $display("FAIL eop_exit: tc/hld/dack got %b/%b/%b want 0100/0/0000", a_tc, a_hld, a_dack);
        end
        hlda = 1'b0; dreq = 4'd0;
        tick;
        n_cmp++;
        if ({a_tc, a_busy} !== {4'b0100, 1'b0}) begin
            n_bad++;
            $display("FAIL eop_sticky: tc/busy got %b/%b want 0100/0", a_tc, a_busy);
        end
        stat_clr = 1'b1;
        tick;
        stat_clr = 1'b0;
        n_cmp++;
        if (a_tc !== 4'd0) begin
            n_bad++;
            $display("FAIL eop_clear: tc got %b want 0000", a_tc);
        end
    endtask

    task automatic test_preempt;
        apply_reset;
        pri_rot = 1'b1; dreq = 4'b0011;
        tick;
        hlda = 1'b1;
        tick;
        n_cmp++;
        if (a_dack !== 4'b0001) begin
            n_bad++;
            $display("FAIL preempt_grant: dack got %b want 0001", a_dack);
        end
        tick;
        hlda = 1'b0;
        tick;
        n_cmp++;
        if ({a_dack, a_hld, a_busy, a_ch_req} !== 7'd0) begin
            n_bad++;
            $display("FAIL preempt_drop: dack/hld/busy/chreq got %b/%b/%b/%b want 0", a_dack, a_hld, a_busy, a_ch_req);
        end
        tick;
        n_cmp++;
        if ({a_hld, a_ch_sel} !== {1'b1, 2'd1}) begin
            n_bad++;
            $display("FAIL preempt_rearb: hld/sel got %b/%0d want 1/1", a_hld, a_ch_sel);
        end
    endtask

    task automatic test_async_reset;
        apply_reset;
        dreq = 4'b0001;
        tick;
        hlda = 1'b1;
        tick; tick;
        n_cmp++;
        if (a_dack !== 4'b0001) begin
            n_bad++;
            $display("FAIL areset_pre: dack got %b want 0001", a_dack);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({a_hld, a_dack, a_ch_sel, a_ch_req, a_busy, a_tc, b_hld, b_dack, b_busy} !== 19'd0) begin
            n_bad++;
            $display("FAIL areset_now: a=%b b_hld/dack/busy=%b/%b/%b want 0",
                     {a_hld, a_dack, a_ch_sel, a_ch_req, a_busy, a_tc}, b_hld, b_dack, b_busy);
        end
        #3 rst = 1'b0;
        tick;
    endtask

    task automatic test_masked;
        apply_reset;
        dreq = 4'b0001; mask = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            tick;
            n_cmp++;
            if ({a_hld, a_busy, b_hld, b_busy} !== 4'd0) begin
                n_bad++;
                $display("FAIL masked_c%0d: hld/busy got %b/%b want 0/0", c, a_hld, a_busy);
            end
        end
    endtask

    task automatic test_random;
        logic [12:0] ga, gb, ea, eb;
        apply_reset;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(3) == 0) dreq = 4'($urandom);
            if ($urandom_range(11) == 0) mask = ($urandom_range(2) == 0) ? 4'($urandom) : 4'd0;
            if ($urandom_range(60) == 0) pri_rot = ~pri_rot;
            if (a_hld) begin
                if (!hlda) hlda = 1'($urandom_range(1));
                else if ($urandom_range(20) == 0) hlda = 1'b0;
            end else if (hlda) hlda = 1'($urandom_range(1));
            eop      = ($urandom_range(7) == 0);
            stat_clr = ($urandom_range(11) == 0);
            tick;
            model_step;
            ga = {a_hld, a_dack, a_ch_sel, a_ch_req, a_busy, a_tc};
            gb = {b_hld, b_dack, b_ch_sel, b_ch_req, b_busy, b_tc};
            ea = exp_out(0);
            eb = exp_out(1);
            n_cmp++;
            if (ga !== ea) begin
                n_bad++;
                $display("FAIL random_a c%0d: hld,dack,sel,chreq,busy,tc got %b want %b", c, ga, ea);
            end
            n_cmp++;
            if (gb !== eb) begin
                n_bad++;
                $display("FAIL random_b c%0d: hld,dack,sel,chreq,busy,tc got %b want %b", c, gb, eb);
            end
            n_cmp++;
            if (!$onehot0(a_dack) || !$onehot0(b_dack)) begin
                n_bad++;
                $display("FAIL random_onehot c%0d: dack got %b/%b want one-hot or zero", c, a_dack, b_dack);
            end
        end
    endtask

    initial begin
        test_reset;
        test_fixed_priority;
        test_rotation;
        test_eop_tc;
        test_preempt;
        test_async_reset;
        test_masked;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
